// File: rtl/cache_pkg.sv
// Shared types and sizing for the data cache and its refill engine.
package cache_pkg;

    localparam int CACHE_DATA_W     = 32;
    localparam int CACHE_ADDR_W     = 30;
    localparam int CACHE_BLOCK_SIZE = 3;
    localparam int WORDS            = 2 ** CACHE_BLOCK_SIZE;
    localparam int LINE_W           = CACHE_DATA_W * WORDS;
    localparam int TAG_W            = CACHE_ADDR_W - CACHE_BLOCK_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_line_buffer.sv
// Line assembly buffer: one register per word slot, cleared asynchronously,
// presented as a flat block-wide vector with word k at bits [k*DW +: DW].
module line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [BLOCK_SIZE-1:0]                wr_slot,
    input  logic [DATA_WIDTH-1:0]                wr_word,
    output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] line_out
);

    localparam int N_WORDS = 2 ** BLOCK_SIZE;

    logic [DATA_WIDTH-1:0] words_r [N_WORDS];

    // Slot storage; untouched slots keep the previous line's data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_WORDS; k++) begin
                words_r[k] <= '0;
            end
        end else if (wr_en) begin
            words_r[wr_slot] <= wr_word;
        end
    end

    // Flatten slots into the block-wide line
    always_comb begin
        line_out = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            line_out[k*DATA_WIDTH +: DATA_WIDTH] = words_r[k];
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill engine: fetches 2**BLOCK_SIZE words one at a time on a miss.
// Optional macro CRITICAL_WORD_FIRST_EN starts at the missed word and adds crit_valid/crit_word.
module cache_refill_ctrl import cache_pkg::*; #(
    parameter int DATA_WIDTH    = CACHE_DATA_W,
    parameter int ADDRESS_WIDTH = CACHE_ADDR_W,
    parameter int BLOCK_SIZE    = CACHE_BLOCK_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  miss_req,
    input  logic [ADDRESS_WIDTH-1:0]              miss_addr,
    output logic                                  mem_rd_en,
    output logic [ADDRESS_WIDTH-1:0]              mem_addr,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    input  logic                                  mem_rvalid,
    output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] line_out,
    output logic                                  line_valid,
    output logic                                  stall
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                                  crit_valid,
    output logic [DATA_WIDTH-1:0]                 crit_word
`endif
);

    localparam int                  N_WORDS    = 2 ** BLOCK_SIZE;
    localparam int                  TAG_BITS   = ADDRESS_WIDTH - BLOCK_SIZE;
    localparam logic [BLOCK_SIZE:0] LAST_COUNT = (BLOCK_SIZE+1)'(N_WORDS - 1);
    localparam logic [BLOCK_SIZE:0] COUNT_ONE  = (BLOCK_SIZE+1)'(1);
    localparam logic [BLOCK_SIZE-1:0] OFFSET_ONE = BLOCK_SIZE'(1);

    refill_state_t           state_r, state_s;
    logic [TAG_BITS-1:0]     tag_r, tag_s;
    logic [BLOCK_SIZE-1:0]   offset_r, offset_s, start_offset_s;
    logic [BLOCK_SIZE:0]     count_r, count_s;
    logic                    wr_en_s;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_offset_s = miss_addr[BLOCK_SIZE-1:0];
`else
    assign start_offset_s = '0;
`endif

    assign wr_en_s = (state_r == WAIT) && mem_rvalid;

    // Next-state and refill bookkeeping; the tag is never incremented so reads stay inside the line
    always_comb begin
        state_s  = state_r;
        tag_s    = tag_r;
        offset_s = offset_r;
        count_s  = count_r;
        case (state_r)
            IDLE: begin
                if (miss_req) begin
                    state_s  = ISSUE;
                    tag_s    = miss_addr[ADDRESS_WIDTH-1:BLOCK_SIZE];
                    offset_s = start_offset_s;
                    count_s  = '0;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    count_s  = count_r + COUNT_ONE;
                    offset_s = offset_r + OFFSET_ONE;
                    if (count_r == LAST_COUNT) begin
                        state_s = DONE;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM and refill position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            tag_r    <= '0;
            offset_r <= '0;
            count_r  <= '0;
        end else begin
            state_r  <= state_s;
            tag_r    <= tag_s;
            offset_r <= offset_s;
            count_r  <= count_s;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            line_valid <= 1'b0;
            stall      <= 1'b0;
        end else begin
            mem_rd_en  <= (state_s == ISSUE);
            line_valid <= (state_s == DONE);
            stall      <= (state_s == ISSUE) || (state_s == WAIT);
            if (state_s == ISSUE) begin
                mem_addr <= {tag_s, offset_s};
            end
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    // The first word returned is always the missed one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit_valid <= 1'b0;
            crit_word  <= '0;
        end else begin
            crit_valid <= wr_en_s && (count_r == '0);
            if (wr_en_s && (count_r == '0)) begin
                crit_word <= mem_rdata;
            end
        end
    end
`endif

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_line_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_slot  (offset_r),
        .wr_word  (mem_rdata),
        .line_out (line_out)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised self-checking bench for cache_refill_ctrl against a cycle-timestamp model
// of the refill protocol, with memory that answers addr*3 after a chosen latency.
module tb_cache_refill_ctrl;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int BS = 3;
    localparam int NW = 8;
    localparam int LW = DW * NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miss_req = 1'b0;
    logic [AW-1:0] miss_addr = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic [LW-1:0] line_out;
    logic          line_valid;
    logic          stall;
`ifdef CRITICAL_WORD_FIRST_EN
    logic          crit_valid;
    logic [DW-1:0] crit_word;
`endif

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .line_out   (line_out),
        .line_valid (line_valid),
        .stall      (stall)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid (crit_valid),
        .crit_word  (crit_word)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model: expected event cycles of the current refill
    bit            busy = 1'b0;
    bit            done_flag = 1'b0;
    bit            first_seen = 1'b0;
    int            acc_cyc = 0, next_rd = -1, lv_cyc = -1, ready_cyc = 0;
    int            resp_cyc = -1, crit_cyc = -1;
    int            issued = 0, got = 0, rd_cnt = 0, lv_obs = -1;
    int            m_start = 0, lat_min = 1, lat_max = 1;
    logic [AW-1:0] m_base = '0, resp_addr = '0, first_addr = '0;
    logic [LW-1:0] exp_line = '0;
    logic [DW-1:0] crit_exp = '0;

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int i);
        return m_base | AW'((m_start + i) % NW);
    endfunction

    task automatic model_reset();
        busy = 1'b0; next_rd = -1; lv_cyc = -1; ready_cyc = 0;
        resp_cyc = -1; crit_cyc = -1; cyc = 0;
    endtask

    task automatic accept(input logic [AW-1:0] a);
        busy = 1'b1; acc_cyc = cyc; next_rd = cyc + 1; lv_cyc = -1;
        issued = 0; got = 0; rd_cnt = 0; first_seen = 1'b0; lv_obs = -1;
        m_base = {a[AW-1:BS], 3'b000};
`ifdef CRITICAL_WORD_FIRST_EN
        m_start = int'(a[BS-1:0]);
`else
        m_start = 0;
`endif
        for (int k = 0; k < NW; k++) begin
            exp_line[k*DW +: DW] = (DW'(m_base) + DW'(k)) * 32'd3;
        end
        crit_exp = DW'(a) * 32'd3;
    endtask

    task automatic compare();
        bit exp_rd;
        exp_rd = busy && (cyc == next_rd);
        check("mem_rd_en", {255'd0, mem_rd_en}, {255'd0, exp_rd});
        if (mem_rd_en === 1'b1) begin
            rd_cnt++;
            if (!first_seen) begin
                first_addr = mem_addr;
                first_seen = 1'b1;
            end
            resp_addr = mem_addr;
            resp_cyc  = cyc + int'($urandom_range(lat_max, lat_min));
        end
        if (exp_rd) begin
            check("mem_addr", LW'(mem_addr), LW'(exp_addr(issued)));
            issued++;
        end
        check("stall", {255'd0, stall}, {255'd0, busy && (cyc > acc_cyc) && (cyc != lv_cyc)});
        check("line_valid", {255'd0, line_valid}, {255'd0, busy && (cyc == lv_cyc)});
        if (line_valid === 1'b1) lv_obs = cyc;
`ifdef CRITICAL_WORD_FIRST_EN
        check("crit_valid", {255'd0, crit_valid}, {255'd0, cyc == crit_cyc});
        if (cyc == crit_cyc) check("crit_word", LW'(crit_word), LW'(crit_exp));
`endif
        if (busy && (cyc == lv_cyc)) begin
            check("line_out", line_out, exp_line);
            busy = 1'b0;
            ready_cyc = cyc + 1;
            done_flag = 1'b1;
        end
    endtask

    // drive one cycle of inputs, let the model see them, then check the next cycle
    task automatic tick(input bit req, input logic [AW-1:0] a, input bit noisy);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (cyc == resp_cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = DW'(resp_addr) * 32'd3;
        end else if (noisy && (!busy || cyc == next_rd) && $urandom_range(2, 0) == 0) begin
            mem_rvalid = 1'b1;
        end
        miss_req  = req;
        miss_addr = a;
        if (req && !busy && cyc >= ready_cyc) begin
            accept(a);
        end else if (busy && cyc == resp_cyc) begin
            got++;
            if (got == 1) crit_cyc = cyc + 1;
            if (got >= NW) lv_cyc = cyc + 1;
            else next_rd = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic run_refill(input logic [AW-1:0] a, input int lmin, input int lmax,
                              input bit noisy, input bit hold, input int abort_words);
        bit accepted;
        bit req;
        logic [AW-1:0] addr;
        accepted = 1'b0;
        done_flag = 1'b0;
        lat_min = lmin;
        lat_max = lmax;
        for (int i = 0; i < 600; i++) begin
            req  = !accepted || (hold && busy);
            addr = (accepted && noisy) ? AW'($urandom) : a;
            tick(req, addr, noisy);
            if (busy) accepted = 1'b1;
            if (abort_words > 0 && got == abort_words && busy && cyc > next_rd && cyc < resp_cyc) return;
            if (done_flag) return;
        end
        checks++;
        errors++;
        $display("FAIL refill_timeout addr %h: got no line_valid expected one within 600 cycles", a);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_rd_en"}, {255'd0, mem_rd_en}, '0);
        check({nm, "_addr"}, LW'(mem_addr), '0);
        check({nm, "_line"}, line_out, '0);
        check({nm, "_valid"}, {255'd0, line_valid}, '0);
        check({nm, "_stall"}, {255'd0, stall}, '0);
`ifdef CRITICAL_WORD_FIRST_EN
        check({nm, "_crit"}, {255'd0, crit_valid}, '0);
`endif
    endtask

    task automatic release_reset();
        miss_req = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare();
    endtask

    initial begin
        logic [DW-1:0] w;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // sequential line at 0x40, single-cycle memory
        run_refill(30'h40, 1, 1, 1'b0, 1'b0, 0);
        check("t1_latency", LW'(lv_obs - acc_cyc), LW'(17));
        check("t1_rd_pulses", LW'(rd_cnt), LW'(8));
        for (int k = 0; k < NW; k++) begin
            w = line_out[k*DW +: DW];
            check("t1_word", LW'(w), LW'((32'h40 + k) * 3));
        end

        // first fetched address for a mid-line miss
        run_refill(30'h45, 1, 1, 1'b0, 1'b0, 0);
`ifdef CRITICAL_WORD_FIRST_EN
        check("t2_first_addr", LW'(first_addr), LW'(30'h45));
`else
        check("t2_first_addr", LW'(first_addr), LW'(30'h40));
`endif

        // top of address space stays inside its line
        run_refill(30'h3FFFFFFF, 1, 1, 1'b0, 1'b0, 0);
`ifdef CRITICAL_WORD_FIRST_EN
        check("t6_first_addr", LW'(first_addr), LW'(30'h3FFFFFFF));
`else
        check("t6_first_addr", LW'(first_addr), LW'(30'h3FFFFFF8));
`endif
        w = line_out[7*DW +: DW];
        check("t6_word7", LW'(w), LW'(32'hBFFFFFFD));

        // slow memory with gaps
        run_refill(30'h1234, 4, 7, 1'b0, 1'b0, 0);
        check("t3_rd_pulses", LW'(rd_cnt), LW'(8));

        // miss_req held and stray rvalids
        run_refill(30'h200, 1, 3, 1'b1, 1'b1, 0);
        check("t4_rd_pulses", LW'(rd_cnt), LW'(8));

        // asynchronous reset while waiting on the fourth word
        run_refill(30'h123, 4, 6, 1'b0, 1'b0, 3);
        rst = 1'b1;
        #2;
        check_reset_outputs("midreset");
        release_reset();
        run_refill(30'h10, 1, 2, 1'b0, 1'b0, 0);
        w = line_out[0 +: DW];
        check("t5_word0", LW'(w), LW'(32'h30));

        for (int n = 0; n < 25; n++) begin
            run_refill(AW'($urandom), 1, int'($urandom_range(5, 1)),
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0);
            repeat (int'($urandom_range(3, 0))) tick(1'b0, '0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
